// File: rtl/sram_pkg.sv
// Shared types and helpers for the synchronous SRAM block.
package sram_pkg;

   // Controller state: CLEAR sweeps INIT_VAL into the array, RUN serves requests.
   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // Address width for a given depth; at least one bit even when DEPTH is 1.
   function automatic int calc_aw(input int depth);
      int aw;
      aw = $clog2(depth);
      return (aw < 1) ? 1 : aw;
   endfunction

endpackage

// File: rtl/sram_array.sv
// Plain DEPTH x DATA_W storage: one lane-masked write port, one async read port.
module sram_array import sram_pkg::*; #(
   parameter int DATA_W = 8,
   parameter int LANE_W = 4,
   parameter int DEPTH  = 16,
   localparam int NLANES = DATA_W / LANE_W,
   localparam int AW     = calc_aw(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [NLANES-1:0] wmask,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Lane-masked write; the array itself is never reset (the clear sweep initialises it).
   always_ff @(posedge clk) begin
      for (int l = 0; l < NLANES; l++) begin
         if (we && wmask[l] && ({1'b0, waddr} < DEPTH_W)) begin
            mem_q[waddr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
         end
      end
   end

   // Asynchronous read; addresses past the end read as zero instead of indexing outside the array.
   always_comb begin
      rdata = '0;
      if ({1'b0, raddr} < DEPTH_W) begin
         rdata = mem_q[raddr];
      end
   end

endmodule

// File: rtl/sram_sync.sv
// Single-port synchronous SRAM with valid/ready requests, lane write mask,
// registered one-entry read response with backpressure, and a clear sweep.
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rd_valid && rd_ready. req_ready is
// a function of state, clr, rd_valid and rd_ready only, never of req_valid.
// busy mirrors the CLEAR state and serves as the observable FSM state.
module sram_sync import sram_pkg::*; #(
   parameter int                DATA_W   = 8,
   parameter int                LANE_W   = 4,
   parameter int                DEPTH    = 16,
   parameter logic [DATA_W-1:0] INIT_VAL = '0,
   localparam int NLANES = DATA_W / LANE_W,
   localparam int AW     = calc_aw(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   output logic              busy,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [AW-1:0]     req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [NLANES-1:0] req_wmask,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_err
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_err_q, rd_err_d;

   logic              req_ready_c;
   logic              req_fire;
   logic              addr_ok;
   logic              arr_we;
   logic [AW-1:0]     arr_waddr;
   logic [DATA_W-1:0] arr_wdata;
   logic [NLANES-1:0] arr_wmask;
   logic [DATA_W-1:0] arr_rdata;

   sram_array #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .waddr (arr_waddr),
      .wdata (arr_wdata),
      .wmask (arr_wmask),
      .raddr (req_addr),
      .rdata (arr_rdata)
   );

   // Request acceptance: only in RUN, not on a clr cycle, and not while a response is stalled.
   always_comb begin
      req_ready_c = (state_q == RUN) && !clr && !(rd_valid_q && !rd_ready);
      req_fire    = req_valid && req_ready_c;
      addr_ok     = ({1'b0, req_addr} < DEPTH_W);
   end

   // Next state and sweep counter; busy follows the next state so it is registered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            if ({1'b0, cnt_q} == LAST_W) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         RUN: begin
            if (clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == CLEAR);
   end

   // Array write port: the sweep owns it in CLEAR, accepted in-range writes in RUN.
   always_comb begin
      arr_we    = 1'b0;
      arr_waddr = req_addr;
      arr_wdata = req_wdata;
      arr_wmask = req_wmask;
      if (state_q == CLEAR) begin
         arr_we    = 1'b1;
         arr_waddr = cnt_q;
         arr_wdata = INIT_VAL;
         arr_wmask = '1;
      end else if (req_fire && req_we && addr_ok) begin
         arr_we = 1'b1;
      end
   end

   // Response register: load on an accepted read, drop on consume, otherwise hold.
   always_comb begin
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      rd_err_d   = rd_err_q;
      if (req_fire && !req_we) begin
         rd_valid_d = 1'b1;
         rd_data_d  = addr_ok ? arr_rdata : '0;
         rd_err_d   = !addr_ok;
      end else if (rd_valid_q && rd_ready) begin
         rd_valid_d = 1'b0;
      end
   end

   // State, counter and output flops with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CLEAR;
         cnt_q      <= '0;
         busy_q     <= 1'b1;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_err_q   <= rd_err_d;
      end
   end

   assign busy      = busy_q;
   assign req_ready = req_ready_c;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign rd_err    = rd_err_q;

endmodule
